// File: rtl/mem_stage.sv
// MIPS memory-access stage: byte/half/word loads and stores against a word-organised
// data memory, registered into MEM/WB. Optional debug read port: MEM_STAGE_DU_PORT_EN.
module mem_stage #(
  parameter int NBITS    = 32,
  parameter int REGS     = 5,
  parameter int MEM_ADDR = 6
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic                i_stall,
  input  logic [NBITS-1:0]    i_alu_result,
  input  logic [NBITS-1:0]    i_store_data,
  input  logic                i_mem_read,
  input  logic                i_mem_write,
  input  logic [1:0]          i_size,
  input  logic                i_unsigned,
  input  logic                i_mem_to_reg,
  input  logic                i_reg_write,
  input  logic [REGS-1:0]     i_reg_dst,
  input  logic [MEM_ADDR-1:0] i_du_addr,
  output logic [NBITS-1:0]    o_wb_data,
  output logic [REGS-1:0]     o_reg_dst,
  output logic                o_reg_write,
  output logic                o_valid,
  output logic                o_misaligned,
  output logic [NBITS-1:0]    o_du_data
);

  logic [NBITS-1:0]    mem [2**MEM_ADDR];
  logic [MEM_ADDR-1:0] word_idx;
  logic [1:0]          lane;
  logic [NBITS-1:0]    rd_word;
  logic [NBITS-1:0]    wr_word;
  logic [NBITS-1:0]    load_ext;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic                misaligned;
  logic                mem_we;

  // Upper address bits are dropped so accesses wrap modulo the memory size.
  assign word_idx = i_alu_result[MEM_ADDR+1:2];
  assign lane     = i_alu_result[1:0];
  assign rd_word  = mem[word_idx];

  assign misaligned = (i_mem_read | i_mem_write) &
                      (((i_size == 2'b01) & lane[0]) | (i_size[1] & (lane != 2'b00)));

  assign mem_we = i_reset & i_valid & i_mem_write & ~i_stall & ~misaligned;

  always_comb begin
    byte_sel = rd_word[{lane, 3'b000} +: 8];
    half_sel = rd_word[{lane[1], 4'b0000} +: 16];
    case (i_size)
      2'b00:   load_ext = {{(NBITS-8){~i_unsigned & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{(NBITS-16){~i_unsigned & half_sel[15]}}, half_sel};
      default: load_ext = rd_word;
    endcase
  end

  // Partial stores merge into the current word so untouched lanes survive.
  always_comb begin
    wr_word = rd_word;
    case (i_size)
      2'b00:   wr_word[{lane, 3'b000} +: 8]      = i_store_data[7:0];
      2'b01:   wr_word[{lane[1], 4'b0000} +: 16] = i_store_data[15:0];
      default: wr_word                           = i_store_data;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem[word_idx] <= wr_word;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_wb_data    <= '0;
      o_reg_dst    <= '0;
      o_reg_write  <= 1'b0;
      o_valid      <= 1'b0;
      o_misaligned <= 1'b0;
    end else if (!i_stall) begin
      o_wb_data    <= i_mem_to_reg ? load_ext : i_alu_result;
      o_reg_dst    <= i_reg_dst;
      o_reg_write  <= i_valid & i_reg_write & ~misaligned;
      o_valid      <= i_valid;
      o_misaligned <= i_valid & misaligned;
    end
  end

`ifdef MEM_STAGE_DU_PORT_EN
  // Non-blocking read returns pre-store contents on a same-cycle store.
  always_ff @(posedge i_clk) begin
    if (!i_reset) o_du_data <= '0;
    else          o_du_data <= mem[i_du_addr];
  end

  logic unused_bits;
  assign unused_bits = ^i_alu_result[NBITS-1:MEM_ADDR+2];
`else
  assign o_du_data = '0;

  logic unused_bits;
  assign unused_bits = ^{i_alu_result[NBITS-1:MEM_ADDR+2], i_du_addr};
`endif

endmodule
